// File: rtl/shift_rr_scheduler_pkg.sv
// Shared definitions for the round-robin shift scheduler.
// Opcodes of the shared shifter and the scheduler FSM encoding.
package shift_rr_scheduler_pkg;

   localparam logic [1:0] OP_SRL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/shift_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr.
// Reusable by any scheduler that shares one resource among n_req clients.
module rr_arbiter
   import shift_rr_scheduler_pkg::*;
#(
   parameter  int n_req = 4,
   localparam int id_w  = $clog2(n_req)
) (
   input  logic [n_req-1:0] req,
   input  logic [id_w-1:0]  ptr,
   output logic [n_req-1:0] win,
   output logic [id_w-1:0]  win_id
);

   logic w_found;

   always_comb begin
      win     = '0;
      win_id  = '0;
      w_found = 1'b0;
      for (int i = 0; i < n_req; i++) begin
         int w_idx;
         w_idx = (int'(ptr) + i) % n_req;
         if (!w_found && req[w_idx]) begin
            w_found    = 1'b1;
            win[w_idx] = 1'b1;
            win_id     = id_w'(w_idx);
         end
      end
   end

endmodule

// File: rtl/shift_rr_scheduler.sv
// Round-robin scheduler sharing one combinational shift/rotate unit.
// Registers operands out, captures the result, returns it with a tagged handshake.
module shift_rr_scheduler
   import shift_rr_scheduler_pkg::*;
#(
   parameter  int width = 8,
   parameter  int n_req = 4,
   localparam int level = $clog2(width),
   localparam int id_w  = $clog2(n_req)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [n_req-1:0]       req,
   input  logic [n_req*width-1:0] req_a,
   input  logic [n_req*level-1:0] req_b,
   input  logic [n_req*2-1:0]     req_op,
   output logic [n_req-1:0]       gnt,
   output logic [width-1:0]       sh_a,
   output logic [level-1:0]       sh_b,
   output logic [1:0]             sh_op,
   input  logic [width-1:0]       sh_y,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [width-1:0]       rsp_y,
   output logic [id_w-1:0]        rsp_id
);

   state_t             r_state;
   logic [id_w-1:0]    r_ptr;
   logic [width-1:0]   r_sh_a;
   logic [level-1:0]   r_sh_b;
   logic [1:0]         r_sh_op;
   logic               r_rsp_valid;
   logic [width-1:0]   r_rsp_y;
   logic [id_w-1:0]    r_rsp_id;

   logic [n_req-1:0]   w_win;
   logic [id_w-1:0]    w_win_id;
   logic               w_idle;
   logic [width-1:0]   w_sel_a;
   logic [level-1:0]   w_sel_b;
   logic [1:0]         w_sel_op;
   logic [id_w-1:0]    w_ptr_nxt;

   rr_arbiter #(
      .n_req (n_req)
   ) u_arb (
      .req    (req),
      .ptr    (r_ptr),
      .win    (w_win),
      .win_id (w_win_id)
   );

   // Reset gates gnt so every output reads zero while rst_n is low.
   assign w_idle   = rst_n && (r_state == S_IDLE);
   assign gnt      = w_idle ? w_win : '0;

   assign w_sel_a  = req_a[int'(w_win_id)*width +: width];
   assign w_sel_b  = req_b[int'(w_win_id)*level +: level];
   assign w_sel_op = req_op[int'(w_win_id)*2 +: 2];

   assign w_ptr_nxt = (r_rsp_id == id_w'(n_req - 1)) ?
                      '0 : r_rsp_id + id_w'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_sh_a      <= '0;
         r_sh_b      <= '0;
         r_sh_op     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_y     <= '0;
         r_rsp_id    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_sh_a   <= w_sel_a;
                  r_sh_b   <= w_sel_b;
                  r_sh_op  <= w_sel_op;
                  r_rsp_id <= w_win_id;
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_y     <= sh_y;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_ptr       <= w_ptr_nxt;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sh_a      = r_sh_a;
   assign sh_b      = r_sh_b;
   assign sh_op     = r_sh_op;
   assign rsp_valid = r_rsp_valid;
   assign rsp_y     = r_rsp_y;
   assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_shift_rr_scheduler.sv
// Bench for shift_rr_scheduler: shared shifter model, grant predictor,
// response scoreboard, directed scenarios and a randomized phase.
module tb_shift_rr_scheduler;
   import shift_rr_scheduler_pkg::*;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int L  = 3;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*W-1:0]  req_a;
   logic [N*L-1:0]  req_b;
   logic [N*2-1:0]  req_op;
   logic [N-1:0]    gnt;
   logic [W-1:0]    sh_a;
   logic [L-1:0]    sh_b;
   logic [1:0]      sh_op;
   logic [W-1:0]    sh_y;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [W-1:0]    rsp_y;
   logic [IW-1:0]   rsp_id;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int         id;
      logic [7:0] y;
      int         gcyc;
   } exp_t;

   exp_t sb[$];
   int   glog_id[$];
   int   glog_cyc[$];

   shift_rr_scheduler #(.width(W), .n_req(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .gnt       (gnt),
      .sh_a      (sh_a),
      .sh_b      (sh_b),
      .sh_op     (sh_op),
      .sh_y      (sh_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_id    (rsp_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared shift/rotate unit living beside the scheduler
   logic [15:0] w_dbl;
   always_comb begin
      w_dbl = '0;
      sh_y  = '0;
      case (sh_op)
         OP_SRL: sh_y = sh_a >> sh_b;
         OP_SLL: sh_y = sh_a << sh_b;
         OP_ROR: begin
            w_dbl = {sh_a, sh_a} >> sh_b;
            sh_y  = w_dbl[7:0];
         end
         default: begin
            w_dbl = {sh_a, sh_a} << sh_b;
            sh_y  = w_dbl[15:8];
         end
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Bit-by-bit reference: output bit i comes from a source bit position
   function automatic logic [7:0] ref_shift(input logic [7:0] a,
                                            input int b,
                                            input logic [1:0] op);
      logic [7:0] y;
      int s;
      y = '0;
      for (int i = 0; i < 8; i++) begin
         case (op)
            2'b00: begin s = i + b; y[i] = (s < 8) ? a[s] : 1'b0; end
            2'b01: begin s = i - b; y[i] = (s >= 0) ? a[s] : 1'b0; end
            2'b10: begin s = (i + b) % 8; y[i] = a[s]; end
            default: begin s = (i - b + 8) % 8; y[i] = a[s]; end
         endcase
      end
      return y;
   endfunction

   // Grant predictor: pushes expectation into the scoreboard on every grant
   bit busy = 0;
   int mptr = 0;
   int cur  = 0;
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            busy = 0;
            mptr = 0;
            sb.delete();
            chk("gnt_in_reset", 32'(gnt), 0);
         end else begin
            logic [N-1:0] eg;
            int w;
            eg = '0;
            w  = -1;
            if (!busy) begin
               for (int i = 0; i < N; i++) begin
                  int k;
                  k = (mptr + i) % N;
                  if (w < 0 && req[k]) w = k;
               end
               if (w >= 0) eg[w] = 1'b1;
            end
            chk("gnt", 32'(gnt), 32'(eg));
            if (w >= 0) begin
               busy = 1;
               cur  = w;
               sb.push_back('{w,
                  ref_shift(req_a[w*W +: W], int'(req_b[w*L +: L]),
                            req_op[w*2 +: 2]),
                  cyc});
               glog_id.push_back(w);
               glog_cyc.push_back(cyc);
            end else if (busy && rsp_valid && rsp_ready) begin
               busy = 0;
               mptr = (cur + 1) % N;
            end
         end
      end
   end

   // Response monitor: pops the scoreboard and checks hold under backpressure
   bit         pv  = 0;
   bit         phs = 0;
   logic [7:0] py;
   logic [1:0] pid;
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            pv  = 0;
            phs = 0;
            chk("rsp_valid_in_reset", 32'(rsp_valid), 0);
         end else begin
            if (rsp_valid) begin
               if (!pv || phs) begin
                  if (sb.size() == 0) begin
                     chk("rsp_unexpected", 32'(rsp_valid), 0);
                  end else begin
                     exp_t e;
                     e = sb.pop_front();
                     chk("rsp_id", 32'(rsp_id), 32'(e.id));
                     chk("rsp_y", 32'(rsp_y), 32'(e.y));
                     chk("rsp_latency", 32'(cyc - e.gcyc), 2);
                  end
               end else begin
                  chk("hold_y", 32'(rsp_y), 32'(py));
                  chk("hold_id", 32'(rsp_id), 32'(pid));
               end
            end else if (pv && !phs) begin
               chk("rsp_valid_dropped", 32'(rsp_valid), 1);
            end
            pv  = rsp_valid;
            phs = rsp_valid && rsp_ready;
            py  = rsp_y;
            pid = rsp_id;
         end
      end
   end

   task automatic chk_zero_outs(input string nm);
      chk(nm, {4'(gnt), sh_a, 5'(sh_b), sh_op, rsp_valid, rsp_y,
               6'(rsp_id)}, 0);
   endtask

   task automatic issue(input int k, input logic [7:0] a,
                        input logic [2:0] b, input logic [1:0] op);
      logic got;
      logic [N-1:0] oh;
      @(posedge clk);
      #1;
      req_a[k*W +: W]  = a;
      req_b[k*L +: L]  = b;
      req_op[k*2 +: 2] = op;
      req[k]           = 1'b1;
      got = 1'b0;
      oh  = '0;
      oh[k] = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         #3;
         got = gnt[k];
      end
      chk("issue_granted", 32'(got), 1);
      if (got) chk("gnt_onehot", 32'(gnt), 32'(oh));
      @(posedge clk);
      #1;
      req[k] = 1'b0;
   endtask

   task automatic wait_rsp(input logic [7:0] ey, input int eid);
      bit seen;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         #3;
         seen = rsp_valid;
      end
      chk("dir_rsp_seen", 32'(seen), 1);
      if (seen) begin
         chk("dir_rsp_y", 32'(rsp_y), 32'(ey));
         chk("dir_rsp_id", 32'(rsp_id), 32'(eid));
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req   = '0;
      #2;
      chk_zero_outs("reset_outs");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #3;
         if (sb.size() == 0 && !rsp_valid && !busy) break;
      end
      chk("drained", 32'(sb.size()), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int n0;
      int cr;
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req       = 4'($urandom);
      req_a     = $urandom;
      req_b     = 12'($urandom);
      req_op    = 8'($urandom);
      repeat (3) begin
         @(negedge clk);
         #3;
         chk_zero_outs("reset_hold_outs");
         @(posedge clk);
         #1;
         req = 4'($urandom);
      end
      req   = '0;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      issue(0, 8'hB5, 3'd3, OP_SRL);
      wait_rsp(8'h16, 0);

      issue(2, 8'h81, 3'd1, OP_SLL);
      wait_rsp(8'h02, 2);
      issue(2, 8'h81, 3'd1, OP_ROR);
      wait_rsp(8'hC0, 2);
      issue(2, 8'h81, 3'd1, OP_ROL);
      wait_rsp(8'h03, 2);
      issue(2, 8'h81, 3'd0, OP_ROR);
      wait_rsp(8'h81, 2);
      drain();

      // Fairness from a fresh pointer
      do_reset();
      n0 = glog_id.size();
      @(posedge clk);
      #1;
      req_a     = $urandom;
      req_b     = 12'($urandom);
      req_op    = 8'($urandom);
      rsp_ready = 1'b1;
      req       = 4'hF;
      repeat (19) @(posedge clk);
      #1;
      req = '0;
      drain();
      chk("fair_count_ok", 32'(glog_id.size() - n0 >= 6), 1);
      if (glog_id.size() - n0 >= 6) begin
         for (int i = 0; i < 6; i++) begin
            chk("fair_order", 32'(glog_id[n0+i]), 32'(i % N));
            if (i > 0)
               chk("fair_interval",
                   32'(glog_cyc[n0+i] - glog_cyc[n0+i-1]), 3);
         end
      end

      // Backpressure with a competing request waiting
      rsp_ready = 1'b0;
      issue(0, 8'hF0, 3'd4, OP_ROR);
      req_a[1*W +: W]  = 8'h3C;
      req_b[1*L +: L]  = 3'd2;
      req_op[1*2 +: 2] = OP_SLL;
      req[1]           = 1'b1;
      wait_rsp(8'h0F, 0);
      n0 = glog_id.size();
      repeat (5) @(posedge clk);
      #1;
      chk("bp_no_gnt", 32'(glog_id.size()), 32'(n0));
      rsp_ready = 1'b1;
      @(negedge clk);
      cr = cyc;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #3;
         if (glog_id.size() > n0) break;
      end
      chk("bp_regrant_seen", 32'(glog_id.size() > n0), 1);
      if (glog_id.size() > n0) begin
         chk("bp_regrant_cycle", 32'(glog_cyc[n0] - cr), 1);
         chk("bp_regrant_id", 32'(glog_id[n0]), 1);
      end
      @(posedge clk);
      #1;
      req[1] = 1'b0;
      wait_rsp(8'hF0, 1);
      drain();

      // Reset while a transaction is in EXEC
      issue(1, 8'h5A, 3'd2, OP_SRL);
      rst_n = 1'b0;
      #2;
      chk_zero_outs("mid_exec_reset_outs");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #3;
         chk("after_reset_valid", 32'(rsp_valid), 0);
      end
      issue(3, 8'hA5, 3'd5, OP_ROL);
      wait_rsp(8'hB4, 3);
      drain();

      // Randomized traffic with random backpressure and withdrawals
      for (int c = 0; c < 700; c++) begin
         logic [N-1:0] gs;
         @(negedge clk);
         #3;
         gs = gnt;
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (gs[k] || (!req[k] && $urandom_range(0, 3) == 0)) begin
               if ($urandom_range(0, 1) == 1) begin
                  req_a[k*W +: W]  = 8'($urandom);
                  req_b[k*L +: L]  = 3'($urandom);
                  req_op[k*2 +: 2] = 2'($urandom);
                  req[k]           = 1'b1;
               end else begin
                  req[k] = 1'b0;
               end
            end else if (req[k] && $urandom_range(0, 31) == 0) begin
               req[k] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
      end
      req       = '0;
      rsp_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
